// File: rtl/odl_wrr_lock_arb_pkg.sv
// ---------------------------------------------------------------------------
// odl_arb_pkg
// Shared types and helpers for the weighted round-robin lock arbiter.
//   arb_state_e : arbiter FSM state (idle / locked to an owner)
//   onehot2idx  : encodes a one-hot vector (up to ARB_MAX_PORT bits) to an
//                 index; returns 0 for an all-zero input.
// ---------------------------------------------------------------------------
package odl_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Widest port count the encoder helper supports; callers zero-extend.
  localparam int ARB_MAX_PORT  = 64;
  localparam int ARB_IDX_MAX_W = 6;

  function automatic logic [ARB_IDX_MAX_W-1:0] onehot2idx(
    input logic [ARB_MAX_PORT-1:0] oh
  );
    logic [ARB_IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_PORT; i++) begin
      if (oh[i]) idx = idx | ARB_IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/odl_wrr_lock_arb_if.sv
// ---------------------------------------------------------------------------
// odl_wrr_lock_arb_if
// Request/grant bundle between NUM_PORT burst sources and the arbiter.
//   req_i     : per-port valid, held until the last beat is accepted
//   last_i    : per-port last-beat flag, qualified by req_i
//   wt_i      : per-port weight (transactions per round), 0 = disabled
//   ready_i   : downstream accepts the current beat
//   gnt_o     : one-hot grant
//   gnt_vld_o : any grant active
//   gnt_idx_o : encoded grant index, 0 when no grant
//   busy_o    : arbiter locked mid-transaction
// master = requester/downstream side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface odl_wrr_lock_arb_if #(
  parameter int NUM_PORT  = 8,
  parameter int WT_WIDTH  = 4,
  parameter int IDX_WIDTH = $clog2(NUM_PORT)
);

  logic [NUM_PORT-1:0]  req_i;
  logic [NUM_PORT-1:0]  last_i;
  logic [WT_WIDTH-1:0]  wt_i [NUM_PORT];
  logic                 ready_i;
  logic [NUM_PORT-1:0]  gnt_o;
  logic                 gnt_vld_o;
  logic [IDX_WIDTH-1:0] gnt_idx_o;
  logic                 busy_o;

  modport master (
    output req_i, last_i, wt_i, ready_i,
    input  gnt_o, gnt_vld_o, gnt_idx_o, busy_o
  );

  modport slave (
    input  req_i, last_i, wt_i, ready_i,
    output gnt_o, gnt_vld_o, gnt_idx_o, busy_o
  );

endinterface

// File: rtl/odl_rr_ptr_pick.sv
// ---------------------------------------------------------------------------
// odl_rr_ptr_pick
// Combinational round-robin pick: fixed lowest-index priority over the
// eligible ports inside the thermometer pointer, falling back to the full
// eligible set when nothing inside the pointer is eligible.
//   i_elig     : eligible ports
//   i_ptr      : thermometer mask, lowest set bit = highest priority port
//   o_win_oh   : winner, one-hot (0 if nothing eligible)
//   o_hi_therm : ports strictly above the winner (0 if no winner)
//   o_reload   : pointer window was empty, winner came from the full set
// ---------------------------------------------------------------------------
module odl_rr_ptr_pick #(
  parameter int NUM_PORT = 8
) (
  input  logic [NUM_PORT-1:0] i_elig,
  input  logic [NUM_PORT-1:0] i_ptr,
  output logic [NUM_PORT-1:0] o_win_oh,
  output logic [NUM_PORT-1:0] o_hi_therm,
  output logic                o_reload
);

  logic [NUM_PORT-1:0] w_masked;
  logic [NUM_PORT-1:0] w_sel;

  assign w_masked = i_elig & i_ptr;
  assign o_reload = (w_masked == '0);
  assign w_sel    = o_reload ? i_elig : w_masked;

  // Isolate lowest set bit.
  assign o_win_oh = w_sel & (~w_sel + NUM_PORT'(1));

  // Bits at or below the winner are (win | win-1); everything else is above.
  // With no winner, win-1 is all ones and the result collapses to zero.
  assign o_hi_therm = ~(o_win_oh | (o_win_oh - NUM_PORT'(1)));

endmodule

// File: rtl/odl_wrr_lock_arb.sv
// ---------------------------------------------------------------------------
// odl_wrr_lock_arb
// Weighted round-robin arbiter with transaction locking. A port wins for a
// whole transaction (first accepted beat to accepted last beat); weights
// count transactions per round and a zero weight disables the port.
//
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset (also forces grant low)
//   bus        : odl_wrr_lock_arb_if.slave (req/last/wt/ready in,
//                gnt/gnt_vld/gnt_idx/busy out)
//   perf_clr_i : (ODL_WRR_PERF_CNT_EN only) clear all perf counters
//   perf_cnt_o : (ODL_WRR_PERF_CNT_EN only) per-port completed transaction
//                count, saturating
//
// Optional feature macro: ODL_WRR_PERF_CNT_EN
// Supports NUM_PORT up to odl_arb_pkg::ARB_MAX_PORT.
// ---------------------------------------------------------------------------
module odl_wrr_lock_arb
  import odl_arb_pkg::*;
#(
  parameter int NUM_PORT  = 8,
  parameter int WT_WIDTH  = 4,
  parameter int IDX_WIDTH = $clog2(NUM_PORT)
`ifdef ODL_WRR_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  odl_wrr_lock_arb_if.slave   bus
`ifdef ODL_WRR_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_cnt_o [NUM_PORT],
  input  logic                 perf_clr_i
`endif
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IDX_WIDTH-1:0] r_owner;
  logic                 r_reload_q;
  logic [NUM_PORT-1:0]  r_owner_hi;
  logic [NUM_PORT-1:0]  r_ptr;
  logic [WT_WIDTH-1:0]  r_used [NUM_PORT];

  logic [NUM_PORT-1:0]  w_elig;
  logic [NUM_PORT-1:0]  w_win_oh;
  logic [NUM_PORT-1:0]  w_hi;
  logic                 w_reload;
  logic [NUM_PORT-1:0]  w_gnt;
  logic [NUM_PORT-1:0]  w_gnt_hi;
  logic                 w_busy;
  logic                 w_rld;
  logic [IDX_WIDTH-1:0] w_g;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_done;
  logic                 w_lock;
  logic [WT_WIDTH:0]    w_base;
  logic [WT_WIDTH:0]    w_inc;
  logic                 w_exh;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_elig[i] = bus.req_i[i] & (bus.wt_i[i] != '0);
    end
  end

  odl_rr_ptr_pick #(
    .NUM_PORT (NUM_PORT)
  ) u_pick (
    .i_elig     (w_elig),
    .i_ptr      (r_ptr),
    .o_win_oh   (w_win_oh),
    .o_hi_therm (w_hi),
    .o_reload   (w_reload)
  );

  // Grant/outputs. Gating with rst_i makes the idle grant drop while reset
  // is held, not just after the state register clears.
  always_comb begin
    w_gnt    = '0;
    w_busy   = 1'b0;
    w_rld    = w_reload;
    w_gnt_hi = w_hi;
    if (!rst_i) begin
      if (r_state == ARB_LOCKED) begin
        w_gnt    = NUM_PORT'(1) << r_owner;
        w_busy   = 1'b1;
        w_rld    = r_reload_q;
        w_gnt_hi = r_owner_hi;
      end else begin
        w_gnt = w_win_oh;
      end
    end
  end

  assign w_g    = IDX_WIDTH'(onehot2idx(ARB_MAX_PORT'(w_gnt)));
  assign w_xfer = (|w_gnt) & bus.req_i[w_g] & bus.ready_i;
  assign w_last = bus.last_i[w_g];
  assign w_done = w_xfer & w_last;
  assign w_lock = (r_state == ARB_IDLE) & w_xfer & ~w_last;

  // Weight accounting, one bit wider so base+1 never wraps.
  assign w_base = w_rld ? '0 : {1'b0, r_used[w_g]};
  assign w_inc  = w_base + (WT_WIDTH+1)'(1);
  assign w_exh  = (w_inc >= {1'b0, bus.wt_i[w_g]});

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ARB_IDLE) begin
      if (w_lock) w_state_nxt = ARB_LOCKED;
    end else begin
      if (w_done) w_state_nxt = ARB_IDLE;
    end
  end

  assign bus.gnt_o     = w_gnt;
  assign bus.gnt_vld_o = |w_gnt;
  assign bus.gnt_idx_o = w_g;
  assign bus.busy_o    = w_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '1;
      r_owner    <= '0;
      r_reload_q <= 1'b0;
      r_owner_hi <= '0;
      for (int i = 0; i < NUM_PORT; i++) r_used[i] <= '0;
    end else begin
      if (w_lock) begin
        r_owner    <= w_g;
        r_reload_q <= w_reload;
        r_owner_hi <= w_hi;
      end
      if (w_done) begin
        for (int i = 0; i < NUM_PORT; i++) begin
          if (w_gnt[i])   r_used[i] <= w_exh ? '0 : w_inc[WT_WIDTH-1:0];
          else if (w_rld) r_used[i] <= '0;
        end
        // Exhausted: pass priority past the owner; otherwise keep it on top.
        r_ptr <= w_exh ? w_gnt_hi : (w_gnt_hi | w_gnt);
      end else if ((r_state == ARB_IDLE) && (w_elig == '0)) begin
        r_ptr <= '1;
      end
    end
  end

`ifdef ODL_WRR_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_perf [NUM_PORT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PORT; i++) r_perf[i] <= '0;
    end else if (perf_clr_i) begin
      for (int i = 0; i < NUM_PORT; i++) r_perf[i] <= '0;
    end else if (w_done) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (w_gnt[i] && (r_perf[i] != '1)) r_perf[i] <= r_perf[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORT; i++) perf_cnt_o[i] = r_perf[i];
  end
`endif

endmodule

// File: tb/tb_odl_wrr_lock_arb.sv
// ---------------------------------------------------------------------------
// tb_odl_wrr_lock_arb
// Directed bench for odl_wrr_lock_arb with NUM_PORT=4, WT_WIDTH=3.
// Each step drives req/last/ready, queues the expected grant and busy, then
// pops and checks them before the next rising edge.
// ---------------------------------------------------------------------------
module tb_odl_wrr_lock_arb;

  localparam int NP = 4;
  localparam int WW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  odl_wrr_lock_arb_if #(.NUM_PORT(NP), .WT_WIDTH(WW), .IDX_WIDTH(IW)) bus ();

`ifdef ODL_WRR_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_cnt [NP];
`endif

  odl_wrr_lock_arb #(.NUM_PORT(NP), .WT_WIDTH(WW), .IDX_WIDTH(IW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus.slave)
`ifdef ODL_WRR_PERF_CNT_EN
    ,
    .perf_cnt_o (perf_cnt),
    .perf_clr_i (perf_clr)
`endif
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    step_no = 0;
  string tag     = "reset";

  logic [NP-1:0] q_gnt  [$];
  logic          q_busy [$];

  function automatic logic [IW-1:0] enc(input logic [NP-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) if (oh[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check_out(input logic [NP-1:0] eg, input logic eb);
    n_tests++;
    assert (bus.gnt_o === eg) else begin
      n_fail++;
      $error("FAIL %s#%0d gnt_o observed=%b expected=%b", tag, step_no, bus.gnt_o, eg);
    end
    n_tests++;
    assert (bus.gnt_vld_o === (|eg)) else begin
      n_fail++;
      $error("FAIL %s#%0d gnt_vld_o observed=%b expected=%b", tag, step_no, bus.gnt_vld_o, |eg);
    end
    n_tests++;
    assert (bus.gnt_idx_o === enc(eg)) else begin
      n_fail++;
      $error("FAIL %s#%0d gnt_idx_o observed=%0d expected=%0d", tag, step_no, bus.gnt_idx_o, enc(eg));
    end
    n_tests++;
    assert (bus.busy_o === eb) else begin
      n_fail++;
      $error("FAIL %s#%0d busy_o observed=%b expected=%b", tag, step_no, bus.busy_o, eb);
    end
  endtask

  task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] last,
                      input logic rdy, input logic [NP-1:0] eg, input logic eb);
    logic [NP-1:0] pg;
    logic          pb;
    bus.req_i   = req;
    bus.last_i  = last;
    bus.ready_i = rdy;
    q_gnt.push_back(eg);
    q_busy.push_back(eb);
    #1;
    pg = q_gnt.pop_front();
    pb = q_busy.pop_front();
    check_out(pg, pb);
    @(posedge clk);
    #1;
    step_no++;
  endtask

  task automatic set_wt(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        input logic [WW-1:0] w2, input logic [WW-1:0] w3);
    bus.wt_i[0] = w0;
    bus.wt_i[1] = w1;
    bus.wt_i[2] = w2;
    bus.wt_i[3] = w3;
  endtask

  // Holds reset with all ports requesting; outputs must stay at zero.
  task automatic do_reset(input string t);
    tag         = t;
    step_no     = 0;
    rst         = 1'b1;
    bus.req_i   = 4'b1111;
    bus.last_i  = 4'b1111;
    bus.ready_i = 1'b1;
    #1;
    check_out(4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    set_wt(3'd1, 3'd1, 3'd1, 3'd1);

    // Equal weights, single-beat: plain round robin.
    do_reset("rr_equal");
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);

    // Weights {3,1,2,1}: 0,0,0,1,2,2,3 repeating.
    set_wt(3'd3, 3'd1, 3'd2, 3'd1);
    do_reset("wrr_3121");
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
      step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    end

    // Port 1 four-beat burst with ready toggling; port 0 served first so
    // port 1 is next in line.
    set_wt(3'd1, 3'd1, 3'd1, 3'd1);
    do_reset("burst_p1");
    step(4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1101, 1'b1, 4'b0010, 1'b0);
    step(4'b1111, 4'b1101, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 4'b1101, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 4'b1101, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 4'b1101, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);

    // Zero weight disables port 1.
    set_wt(3'd2, 3'd0, 3'd2, 3'd2);
    do_reset("wt_zero");
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b0010, 4'b1111, 1'b1, 4'b0000, 1'b0);

    // Idle with ready low: grant tracks winner, pointer untouched.
    set_wt(3'd1, 3'd1, 3'd1, 3'd1);
    do_reset("idle_noready");
    step(4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b0110, 4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);

    // Lock on port 2, owner drops req (grant held), then async reset.
    do_reset("lock_rst");
    step(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1);
    step(4'b1011, 4'b1111, 1'b1, 4'b0100, 1'b1);
    bus.req_i  = 4'b1111;
    bus.last_i = 4'b0000;
    tag        = "lock_rst_async";
    rst        = 1'b1;
    #1;
    check_out(4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
